// File: rtl/divider_rv.sv
// divider_rv -- iterative signed fixed-point divider with valid/ready handshakes.
//
// Computes quotient = trunc(dividend * 2^FRAC / divisor) (truncated toward
// zero) and a remainder whose sign follows the dividend, using one radix-2
// restoring step per clock on operand magnitudes. One operation is in flight
// at a time; the result is held on the outputs until the consumer takes it.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   ivalid     operands valid
//   iready     divider can accept operands (registered, high only in IDLE)
//   dividend   signed dividend, DIVIDEND bits
//   divisor    signed divisor, DIVISOR bits
//   ovalid     result valid, held until oready
//   oready     consumer accepts result
//   quotient   signed quotient, QW = DIVIDEND+FRAC bits
//   remainder  signed remainder, DIVISOR bits
//   div_zero   divisor was zero for this result
//   overflow   quotient saturated (dividend = MIN, divisor = -1)
//
// Timing (cycle 0 = accept edge): N = QW restoring steps on edges 1..N, sign
// fix-up on edge N+1, ovalid high after edge N+1. A zero divisor skips the
// iteration entirely and the result is written on edge 1.

module divider_rv #(
  parameter int DIVIDEND = 32,
  parameter int DIVISOR  = 24,
  parameter int FRAC     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ivalid,
  output logic                         iready,
  input  logic [DIVIDEND-1:0]          dividend,
  input  logic [DIVISOR-1:0]           divisor,
  output logic                         ovalid,
  input  logic                         oready,
  output logic [DIVIDEND+FRAC-1:0]     quotient,
  output logic [DIVISOR-1:0]           remainder,
  output logic                         div_zero,
  output logic                         overflow
);

  localparam int QW    = DIVIDEND + FRAC;
  localparam int CNT_W = (QW > 2) ? $clog2(QW) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QW - 1);
  localparam logic [QW-1:0]    Q_MAX    = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0]    Q_MIN    = {1'b1, {(QW-1){1'b0}}};
  localparam logic [QW-1:0]    Q_ZERO   = {QW{1'b0}};
  localparam logic [DIVISOR-1:0] R_ZERO = {DIVISOR{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_FIX  = 3'd2,
    ST_ZERO = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Iteration state: num_r starts as the shifted dividend magnitude and is
  // progressively replaced from the bottom by quotient bits.
  logic [QW-1:0]        num_r;
  logic [DIVISOR:0]     dsr_r;
  logic [DIVISOR-1:0]   rem_r;
  logic [CNT_W-1:0]     count_r;
  logic                 neg_q_r;
  logic                 neg_rem_r;

  // Registered outputs.
  logic                 iready_r;
  logic                 ovalid_r;
  logic [QW-1:0]        quotient_r;
  logic [DIVISOR-1:0]   remainder_r;
  logic                 div_zero_r;
  logic                 overflow_r;

  // Combinational helpers.
  logic                 accept_s;
  logic                 divisor_zero_s;
  logic [DIVIDEND:0]    dvd_ext_s;
  logic [DIVIDEND:0]    dvd_abs_s;
  logic [DIVISOR:0]     dsr_ext_s;
  logic [DIVISOR:0]     dsr_abs_s;
  logic [QW-1:0]        num_init_s;
  logic [DIVISOR:0]     rem_shift_s;
  logic [DIVISOR:0]     rem_diff_s;
  logic                 step_ge_s;
  logic                 q_sat_s;

  assign accept_s       = ivalid & iready_r & (state_r == ST_IDLE);
  assign divisor_zero_s = (divisor == {DIVISOR{1'b0}});

  // Operand magnitudes, formed one bit wider than the operand so that the
  // most negative value converts to its true positive magnitude.
  always_comb begin
    dvd_ext_s  = {dividend[DIVIDEND-1], dividend};
    dsr_ext_s  = {divisor[DIVISOR-1], divisor};
    if (dividend[DIVIDEND-1]) begin
      dvd_abs_s = -dvd_ext_s;
    end else begin
      dvd_abs_s = dvd_ext_s;
    end
    if (divisor[DIVISOR-1]) begin
      dsr_abs_s = -dsr_ext_s;
    end else begin
      dsr_abs_s = dsr_ext_s;
    end
    // |dividend| <= 2^(DIVIDEND-1), so after scaling it always fits QW bits.
    num_init_s = QW'(dvd_abs_s) << FRAC;
  end

  // One restoring step: shift in the next numerator bit, subtract the divisor
  // and keep the difference only when it did not borrow.
  always_comb begin
    rem_shift_s = {rem_r, num_r[QW-1]};
    rem_diff_s  = rem_shift_s - dsr_r;
    // rem_shift_s < 2*|divisor| <= 2^DIVISOR, so the top bit of the
    // difference is a clean borrow flag.
    step_ge_s   = ~rem_diff_s[DIVISOR];
    // A positive quotient magnitude of 2^(QW-1) cannot be represented; this
    // only happens for dividend = MIN, divisor = -1.
    q_sat_s     = ~neg_q_r & num_r[QW-1];
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (divisor_zero_s) begin
            state_next_s = ST_ZERO;
          end else begin
            state_next_s = ST_CALC;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (count_r == CNT_ZERO) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_FIX:  state_next_s = ST_DONE;
      ST_ZERO: state_next_s = ST_DONE;
      ST_DONE: begin
        if (oready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake flags follow the state being entered so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iready_r <= 1'b0;
      ovalid_r <= 1'b0;
    end else begin
      iready_r <= (state_next_s == ST_IDLE);
      ovalid_r <= (state_next_s == ST_DONE);
    end
  end

  // Datapath: operand capture, iteration, and result write-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_r       <= Q_ZERO;
      dsr_r       <= {(DIVISOR+1){1'b0}};
      rem_r       <= R_ZERO;
      count_r     <= CNT_ZERO;
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      quotient_r  <= Q_ZERO;
      remainder_r <= R_ZERO;
      div_zero_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            num_r      <= num_init_s;
            dsr_r      <= dsr_abs_s;
            rem_r      <= R_ZERO;
            count_r    <= CNT_LAST;
            neg_q_r    <= dividend[DIVIDEND-1] ^ divisor[DIVISOR-1];
            neg_rem_r  <= dividend[DIVIDEND-1];
            // Flags describe only the result being produced next.
            div_zero_r <= 1'b0;
            overflow_r <= 1'b0;
          end
        end
        ST_CALC: begin
          if (step_ge_s) begin
            rem_r <= rem_diff_s[DIVISOR-1:0];
          end else begin
            rem_r <= rem_shift_s[DIVISOR-1:0];
          end
          num_r   <= {num_r[QW-2:0], step_ge_s};
          count_r <= count_r - CNT_ONE;
        end
        ST_FIX: begin
          if (q_sat_s) begin
            quotient_r  <= Q_MAX;
            remainder_r <= R_ZERO;
            overflow_r  <= 1'b1;
          end else begin
            quotient_r  <= neg_q_r ? -num_r : num_r;
            remainder_r <= neg_rem_r ? -rem_r : rem_r;
            overflow_r  <= 1'b0;
          end
          div_zero_r <= 1'b0;
        end
        ST_ZERO: begin
          // Saturate toward the sign of the dividend.
          quotient_r  <= neg_rem_r ? Q_MIN : Q_MAX;
          remainder_r <= R_ZERO;
          div_zero_r  <= 1'b1;
          overflow_r  <= 1'b0;
        end
        ST_DONE: begin
          quotient_r <= quotient_r;
        end
        default: begin
          quotient_r <= quotient_r;
        end
      endcase
    end
  end

  assign iready    = iready_r;
  assign ovalid    = ovalid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_divider_rv.sv
// Self-checking bench for divider_rv: two instances (FRAC=0 and FRAC=8)
// driven with directed and random operations, compared against an
// arithmetic reference model built on 64-bit integer division.

module tb_divider_rv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ivalid = 1'b0;
  logic        oready = 1'b1;
  logic        sel    = 1'b0;
  logic [31:0] dvd    = 32'd0;
  logic [23:0] dsr    = 24'd0;

  logic        iv0, iv1, ir0, ir1, ov0, ov1, dz0, dz1, of0, of1;
  logic [31:0] q0;
  logic [39:0] q1;
  logic [23:0] r0, r1;

  assign iv0 = ivalid & ~sel;
  assign iv1 = ivalid & sel;

  divider_rv #(.DIVIDEND(32), .DIVISOR(24), .FRAC(0)) dut0 (
    .clock(clk), .reset(rst), .ivalid(iv0), .iready(ir0),
    .dividend(dvd), .divisor(dsr), .ovalid(ov0), .oready(oready),
    .quotient(q0), .remainder(r0), .div_zero(dz0), .overflow(of0)
  );

  divider_rv #(.DIVIDEND(32), .DIVISOR(24), .FRAC(8)) dut8 (
    .clock(clk), .reset(rst), .ivalid(iv1), .iready(ir1),
    .dividend(dvd), .divisor(dsr), .ovalid(ov1), .oready(oready),
    .quotient(q1), .remainder(r1), .div_zero(dz1), .overflow(of1)
  );

  // View of whichever instance is currently selected, sign-extended to 64 bits.
  logic        c_iready, c_ovalid, c_dz, c_of;
  logic [63:0] c_q, c_r;
  always_comb begin
    if (sel) begin
      c_iready = ir1; c_ovalid = ov1; c_dz = dz1; c_of = of1;
      c_q = {{24{q1[39]}}, q1};
      c_r = {{40{r1[23]}}, r1};
    end else begin
      c_iready = ir0; c_ovalid = ov0; c_dz = dz0; c_of = of0;
      c_q = {{32{q0[31]}}, q0};
      c_r = {{40{r0[23]}}, r0};
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: q = trunc(a*2^frac / b) in QW = 32+frac bits, saturating.
  task automatic model(input int frac, input longint a, input longint b,
                       output longint q, output longint r, output bit dz, output bit ovf);
    longint one, qmax, qmin, num;
    one  = 64'sd1;
    qmax = (one <<< (31 + frac)) - one;
    qmin = -qmax - one;
    num  = a * (one <<< frac);
    if (b == 64'sd0) begin
      dz = 1'b1; ovf = 1'b0; r = 64'sd0;
      q  = (a >= 64'sd0) ? qmax : qmin;
    end else begin
      dz = 1'b0;
      q  = num / b;
      if (q > qmax) begin
        q = qmax; ovf = 1'b1; r = 64'sd0;
      end else begin
        ovf = 1'b0; r = num - q * b;
      end
    end
  endtask

  // Issue one operation, measure latency, and compare the held result.
  task automatic run_op(input bit s, input logic [31:0] a, input logic [23:0] b, input string tag);
    longint eq, er;
    bit     edz, eov, busy_rdy;
    int     lat, exp_lat, k;
    model(s ? 8 : 0, longint'($signed(a)), longint'($signed(b)), eq, er, edz, eov);
    exp_lat = (b == 24'd0) ? 1 : (s ? 41 : 33);
    @(negedge clk);
    sel = s;
    k = 0;
    while (c_iready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_iready"}, {63'd0, c_iready}, 64'd1);
    dvd = a; dsr = b; ivalid = 1'b1;
    @(posedge clk);
    #1 ivalid = 1'b0;
    lat = 0; busy_rdy = 1'b0;
    while (c_ovalid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (c_ovalid !== 1'b1 && c_iready !== 1'b0) busy_rdy = 1'b1;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_ready"}, {63'd0, busy_rdy}, 64'd0);
    check({tag, "_q"}, c_q, eq);
    check({tag, "_r"}, c_r, er);
    check({tag, "_dz"}, {63'd0, c_dz}, {63'd0, edz});
    check({tag, "_ovf"}, {63'd0, c_of}, {63'd0, eov});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] hold_q, hold_r;
    logic [31:0] ra;
    logic [23:0] rb;
    int          mode;
    bit          rs;

    // Reset state.
    #12;
    check("rst_iready", {63'd0, ir0}, 64'd0);
    check("rst_ovalid", {63'd0, ov0}, 64'd0);
    check("rst_q", c_q, 64'd0);
    check("rst_flags", {62'd0, dz0, of0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_iready_low", {63'd0, ir0}, 64'd0);
    @(posedge clk);
    #1 check("rel_iready_high", {63'd0, ir0}, 64'd1);

    // Directed cases.
    run_op(1'b0, 32'd100, 24'd5, "t1");
    check("t1_q_const", c_q, 64'd20);
    run_op(1'b0, -32'sd103, 24'd5, "t2a");
    check("t2a_r_const", c_r, -64'sd3);
    run_op(1'b0, 32'd103, -24'sd5, "t2b");
    check("t2b_q_const", c_q, -64'sd20);
    run_op(1'b0, -32'sd100, -24'sd5, "t2c");
    run_op(1'b1, 32'd1, 24'd3, "t3a");
    check("t3a_q_const", c_q, 64'd85);
    run_op(1'b1, 32'd3, 24'd2, "t3b");
    check("t3b_q_const", c_q, 64'd384);
    run_op(1'b0, 32'd7, 24'd0, "t4a");
    check("t4a_q_const", c_q, 64'h0000_0000_7FFF_FFFF);
    run_op(1'b0, -32'sd7, 24'd0, "t4b");
    check("t4b_q_const", c_q, 64'hFFFF_FFFF_8000_0000);
    run_op(1'b0, 32'h8000_0000, 24'hFF_FFFF, "t5a");
    check("t5a_ovf_const", {63'd0, c_of}, 64'd1);
    run_op(1'b0, 32'h8000_0000, 24'd1, "t5b");
    run_op(1'b1, 32'h8000_0000, 24'hFF_FFFF, "t5c");

    // Back-pressure: result held while oready is low, ivalid ignored.
    oready = 1'b0;
    run_op(1'b0, 32'd1000, 24'd7, "t6");
    hold_q = c_q; hold_r = c_r;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ivalid = 1'b1; dvd = $urandom; dsr = 24'd3;
      @(posedge clk);
      #1;
      check("t6_hold_ovalid", {63'd0, ov0}, 64'd1);
      check("t6_hold_iready", {63'd0, ir0}, 64'd0);
      check("t6_hold_q", c_q, 64'd142);
      check("t6_hold_r", c_r, 64'd6);
    end
    @(negedge clk);
    ivalid = 1'b0; oready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rel_ovalid", {63'd0, ov0}, 64'd0);
    check("t6_rel_iready", {63'd0, ir0}, 64'd1);
    check("t6_rel_q_kept", c_q, hold_q);
    check("t6_rel_r_kept", c_r, hold_r);

    // Reset in the middle of an iteration.
    @(negedge clk);
    sel = 1'b0; dvd = 32'd12345; dsr = 24'd11; ivalid = 1'b1;
    @(posedge clk);
    #1 ivalid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_iready", {63'd0, ir0}, 64'd0);
    check("t7_rst_ovalid", {63'd0, ov0}, 64'd0);
    check("t7_rst_q", c_q, 64'd0);
    check("t7_rst_r", c_r, 64'd0);
    check("t7_rst_flags", {62'd0, dz0, of0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'd12345, 24'd11, "t7_after");

    // Randomized operations on both instances.
    for (int i = 0; i < 30; i++) begin
      rs   = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = 24'($urandom);
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb = 24'd0;
        1: rb = ($urandom_range(0, 1) == 0) ? 24'd1 : 24'hFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 24'($signed($urandom_range(0, 40)) - 20);
        4: rb = 24'h80_0000;
        default: rb = rb;
      endcase
      run_op(rs, ra, rb, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
